// File: rtl/fml_throttle_pkg.sv
// Shared definitions for the FML token-bucket throttle: gate state encoding
// and the width of the stall statistics counter.
package fml_throttle_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } gate_state_t;

    localparam int STAT_W = 32;

endpackage

// File: rtl/fml_throttle_bucket.sv
// Refill timer plus saturating credit counter. A refill fires whenever the
// down-counter sits at zero; each consume removes one credit, never below zero.
module fml_throttle_bucket #(
    parameter int cw = 8,
    parameter int pw = 16
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [pw-1:0] cfg_period,
    input  logic [cw-1:0] cfg_quantum,
    input  logic [cw-1:0] cfg_max,
    input  logic          consume,
    output logic [cw-1:0] credits
);

    localparam logic [pw-1:0] P_ONE = {{(pw-1){1'b0}}, 1'b1};
    localparam logic [cw-1:0] C_ONE = {{(cw-1){1'b0}}, 1'b1};

    logic [pw-1:0] r_timer;
    logic [cw-1:0] r_credits;
    logic          w_refill;
    logic [pw-1:0] w_reload;
    logic [cw:0]   w_sum;
    logic [cw:0]   w_capped;
    logic [cw-1:0] w_next;

    assign w_refill = (r_timer == '0);
    assign w_reload = (cfg_period == '0) ? '0 : cfg_period - P_ONE;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_timer <= '0;
        end else if (w_refill) begin
            r_timer <= w_reload;
        end else begin
            r_timer <= r_timer - P_ONE;
        end
    end

    // Cap only on refill cycles so a lowered cfg_max lets excess credits drain.
    always_comb begin
        w_sum    = {1'b0, r_credits} + (w_refill ? {1'b0, cfg_quantum} : '0);
        w_capped = w_sum;
        if (w_refill && (w_sum > {1'b0, cfg_max})) begin
            w_capped = {1'b0, cfg_max};
        end
        w_next = w_capped[cw-1:0];
        if (consume && (w_capped != '0)) begin
            w_next = w_capped[cw-1:0] - C_ONE;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_credits <= '0;
        end else begin
            r_credits <= w_next;
        end
    end

    assign credits = r_credits;

endmodule

// File: rtl/fml_throttle.sv
// Token-bucket throttle between one FML master and an arbiter port: gates the
// strobe on available credit while passing every data path straight through.
module fml_throttle
    import fml_throttle_pkg::*;
#(
    parameter int fml_depth = 26,
    parameter int cw        = 8,
    parameter int pw        = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cfg_enable,
    input  logic [pw-1:0]        cfg_period,
    input  logic [cw-1:0]        cfg_quantum,
    input  logic [cw-1:0]        cfg_max,
    input  logic                 stat_clear,
    output logic [STAT_W-1:0]    stat_stall,
    output logic [cw-1:0]        credits,
    input  logic [fml_depth-1:0] m_adr,
    input  logic                 m_stb,
    input  logic                 m_we,
    output logic                 m_ack,
    input  logic [7:0]           m_sel,
    input  logic [63:0]          m_di,
    output logic [63:0]          m_do,
    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [7:0]           s_sel,
    input  logic [63:0]          s_di,
    output logic [63:0]          s_do
);

    localparam logic [STAT_W-1:0] S_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    gate_state_t       r_state;
    gate_state_t       w_state_next;
    logic              w_stb;
    logic              w_consume;
    logic [cw-1:0]     w_credits;
    logic [STAT_W-1:0] r_stall;

    assign s_adr = m_adr;
    assign s_we  = m_we;
    assign s_sel = m_sel;
    assign s_do  = m_di;
    assign m_do  = s_di;
    assign m_ack = s_ack;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_stb && !s_ack) w_state_next = ST_HELD;
            ST_HELD: if (s_ack)           w_state_next = ST_IDLE;
            default:                      w_state_next = ST_IDLE;
        endcase
    end

    // Once issued, the strobe follows the master alone until the arbiter acks.
    always_comb begin
        w_stb = 1'b0;
        case (r_state)
            ST_IDLE: w_stb = m_stb && (!cfg_enable || (w_credits != '0));
            ST_HELD: w_stb = m_stb;
            default: w_stb = 1'b0;
        endcase
    end

    assign s_stb     = w_stb;
    assign w_consume = s_ack && cfg_enable;

    fml_throttle_bucket #(
        .cw (cw),
        .pw (pw)
    ) u_bucket (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cfg_period  (cfg_period),
        .cfg_quantum (cfg_quantum),
        .cfg_max     (cfg_max),
        .consume     (w_consume),
        .credits     (w_credits)
    );

    assign credits = w_credits;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_stall <= '0;
        end else if (stat_clear) begin
            r_stall <= '0;
        end else if (m_stb && !w_stb && (r_stall != '1)) begin
            r_stall <= r_stall + S_ONE;
        end
    end

    assign stat_stall = r_stall;

endmodule
